// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared definitions for the memory-access stage. Holds the
//               opcode encodings of ir[31:16], the stage FSM state
//               encodings, the default bus timeout and the counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Opcode field values (ir[31:16]).
    localparam logic [15:0] zNOP  = 16'h0000;
    localparam logic [15:0] zADD  = 16'h0001;
    localparam logic [15:0] zSUB  = 16'h0002;
    localparam logic [15:0] zLD   = 16'h0010;
    localparam logic [15:0] zST   = 16'h0011;
    localparam logic [15:0] zPUSH = 16'h0012;
    localparam logic [15:0] zPOP  = 16'h0013;

    // Stage FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Default bus timeout in cycles; the counter must hold up to 1023.
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W           = 10;

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory-access pipeline stage after the ALU. LD/POP issue a
//               word read, ST/PUSH a word write on the data bus; all other
//               instructions pass through in one registered cycle. Results
//               leave on a valid/ready handshake; a hung bus transaction is
//               aborted after TIMEOUT request cycles.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid/in_ready      - upstream handshake
//               ir, alu_dr, st_data    - instruction, ALU result, store data
//               mem_req/we/addr/wdata  - data bus request side
//               mem_ack/mem_rdata      - data bus response side
//               out_valid/out_ready    - writeback handshake
//               out_ir/alu/mem         - result payload
//               bus_err, align_err     - timeout abort / misaligned address
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ir,
    input  logic [31:0] alu_dr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_alu,
    output logic [31:0] out_mem,
    output logic        bus_err,
    output logic        align_err
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    // Returns {is_mem, is_write, is_pop}.
    function automatic logic [2:0] mem_kind(input logic [31:0] i_ir);
        logic [2:0] k;
        k = 3'b000;
        unique case (i_ir[31:16])
            zLD:     k = 3'b100;
            zPOP:    k = 3'b101;
            zST:     k = 3'b110;
            zPUSH:   k = 3'b110;
            default: k = 3'b000;
        endcase
        return k;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_out_valid;
    logic [31:0]      r_out_ir;
    logic [31:0]      r_out_alu;
    logic [31:0]      r_out_mem;
    logic             r_bus_err;
    logic             r_align_err;

    logic [2:0]       w_kind;
    logic [31:0]      w_ea;
    logic             w_in_ready;
    logic             w_accept;

    assign w_kind     = mem_kind(ir);
    // The ALU hands POP the already-incremented SP; the popped word sits below it.
    assign w_ea       = w_kind[0] ? (alu_dr - 32'd4) : alu_dr;
    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_out_valid <= 1'b0;
            r_out_ir    <= '0;
            r_out_alu   <= '0;
            r_out_mem   <= '0;
            r_bus_err   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        // Any previous result is consumed this edge, so the
                        // output payload registers are free to take the new one.
                        r_out_ir  <= ir;
                        r_out_alu <= alu_dr;
                        r_out_mem <= '0;
                        r_bus_err <= 1'b0;
                        if (w_kind[2]) begin
                            r_align_err <= |w_ea[1:0];
                            r_req       <= 1'b1;
                            r_we        <= w_kind[1];
                            r_addr      <= {w_ea[31:2], 2'b00};
                            r_wdata     <= st_data;
                            r_cnt       <= '0;
                            r_state     <= S_BUS;
                        end else begin
                            r_align_err <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack) begin
                        r_req       <= 1'b0;
                        r_out_mem   <= r_we ? 32'd0 : mem_rdata;
                        r_bus_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (r_cnt == c_cnt_last) begin
                        r_req       <= 1'b0;
                        r_out_mem   <= '0;
                        r_bus_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign out_valid = r_out_valid;
    assign out_ir    = r_out_ir;
    assign out_alu   = r_out_alu;
    assign out_mem   = r_out_mem;
    assign bus_err   = r_bus_err;
    assign align_err = r_align_err;

endmodule : mem_access
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access (TIMEOUT = 4). A vector
//               table covers single transactions; hand-written sequences
//               cover reset, back-to-back pass-through, HOLD stall, late ack
//               after timeout and reset during a bus transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir;
    logic [31:0] alu_dr;
    logic [31:0] st_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_alu;
    logic [31:0] out_mem;
    logic        bus_err;
    logic        align_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .alu_dr    (alu_dr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_alu   (out_alu),
        .out_mem   (out_mem),
        .bus_err   (bus_err),
        .align_err (align_err)
    );

    typedef struct {
        logic [15:0] op;
        logic [31:0] alu;
        logic [31:0] st;
        int          ack_at;     // BUS cycle index carrying mem_ack, -1 = never
        logic [31:0] rdata;
        int          exp_nreq;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_mem;
        logic        exp_berr;
        logic        exp_aerr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry/exit: #1 after a rising edge, stage IDLE with no result pending.
    task automatic run_vec(input int idx, input vec_t v);
        int    nreq;
        logic  is_mem;
        logic [31:0] ir_w;
        is_mem = (v.exp_nreq != 0);
        ir_w   = {v.op, 16'(idx)};
        chk($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        ir       = ir_w;
        alu_dr   = v.alu;
        st_data  = v.st;
        tick();
        in_valid = 1'b0;
        nreq     = 0;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            if (mem_req) nreq++;
            if (c == 0) begin
                chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.exp_we));
                chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
                if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.st);
                chk($sformatf("v%0d in_ready_bus", idx), 32'(in_ready), 32'd0);
            end
            mem_ack   = (c == v.ack_at);
            mem_rdata = mem_ack ? v.rdata : 32'h0BAD_0BAD;
            tick();
            mem_ack = 1'b0;
        end
        chk($sformatf("v%0d req_cycles", idx), 32'(nreq), 32'(v.exp_nreq));
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d mem_req_done", idx), 32'(mem_req), 32'd0);
        chk($sformatf("v%0d out_ir", idx), out_ir, ir_w);
        chk($sformatf("v%0d out_alu", idx), out_alu, v.alu);
        chk($sformatf("v%0d out_mem", idx), out_mem, v.exp_mem);
        chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(v.exp_berr));
        chk($sformatf("v%0d align_err", idx), 32'(align_err), 32'(v.exp_aerr));
        chk($sformatf("v%0d in_ready_out", idx), 32'(in_ready), is_mem ? 32'd0 : 32'd1);
        tick();
        chk($sformatf("v%0d out_valid_clr", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held_mem;
        int          waited;

        //              op     alu            st            ack rdata          nreq we addr           mem            be    ae
        vecs[0] = '{zADD,  32'h0000_0010, 32'h0,        -1, 32'h0,          0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[1] = '{zLD,   32'h0000_0100, 32'h0,         3, 32'hDEAD_BEEF,  4, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{zPUSH, 32'h0000_01FC, 32'h55,        0, 32'h0,          1, 1'b1, 32'h0000_01FC, 32'h0,         1'b0, 1'b0};
        vecs[3] = '{zPOP,  32'h0000_0200, 32'h0,         1, 32'h1234_5678,  2, 1'b0, 32'h0000_01FC, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{zST,   32'h0000_0103, 32'hAA,        0, 32'h0,          1, 1'b1, 32'h0000_0100, 32'h0,         1'b0, 1'b1};
        vecs[5] = '{zLD,   32'h0000_0302, 32'h0,         0, 32'hCAFE_0001,  1, 1'b0, 32'h0000_0300, 32'hCAFE_0001, 1'b0, 1'b1};
        vecs[6] = '{zSUB,  32'h0000_0007, 32'h0,        -1, 32'h0,          0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0};
        vecs[7] = '{zLD,   32'h0000_0040, 32'h0,        -1, 32'h0,          4, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; ir = '0; alu_dr = '0; st_data = '0;
        mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        chk("rst mem_req",   32'(mem_req),   32'd0);
        chk("rst mem_we",    32'(mem_we),    32'd0);
        chk("rst mem_addr",  mem_addr,       32'd0);
        chk("rst mem_wdata", mem_wdata,      32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_ir",    out_ir,         32'd0);
        chk("rst out_alu",   out_alu,        32'd0);
        chk("rst out_mem",   out_mem,        32'd0);
        chk("rst bus_err",   32'(bus_err),   32'd0);
        chk("rst align_err", 32'(align_err), 32'd0);
        chk("rst in_ready",  32'(in_ready),  32'd1);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Late ack after the timeout (last vector) must be ignored.
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        chk("late_ack mem_req",   32'(mem_req),   32'd0);
        chk("late_ack out_valid", 32'(out_valid), 32'd0);
        chk("late_ack in_ready",  32'(in_ready),  32'd1);
        chk("late_ack out_mem",   out_mem,        32'd0);

        // Back-to-back pass-through at full rate, each result replacing the last.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            ir       = {zADD, 16'(k)};
            alu_dr   = 32'hA000_0000 + 32'(k);
            tick();
            chk($sformatf("b2b%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d out_alu", k), out_alu, 32'hA000_0000 + 32'(k));
            chk($sformatf("b2b%0d in_ready", k), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b drained", 32'(out_valid), 32'd0);

        // HOLD stall: result held 5 cycles with out_ready low, new input refused.
        out_ready = 1'b0;
        in_valid  = 1'b1; ir = {zLD, 16'h0077}; alu_dr = 32'h0000_0080;
        tick();
        in_valid  = 1'b1; ir = {zADD, 16'h0088}; alu_dr = 32'h0000_0999;
        mem_ack   = 1'b1; mem_rdata = 32'h0BEE_F00D;
        tick();
        mem_ack   = 1'b0; mem_rdata = 32'h1111_2222;
        held_mem  = 32'h0BEE_F00D;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d out_mem", k), out_mem, held_mem);
            chk($sformatf("hold%0d out_alu", k), out_alu, 32'h0000_0080);
            chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold release out_valid", 32'(out_valid), 32'd0);
        chk("hold release in_ready",  32'(in_ready),  32'd1);
        chk("hold release out_alu",   out_alu,        32'h0000_0080);

        // Reset while the bus transaction is outstanding.
        in_valid = 1'b1; ir = {zST, 16'h0099}; alu_dr = 32'h0000_0500; st_data = 32'h77;
        tick();
        in_valid = 1'b0;
        waited = 0;
        while (!mem_req && waited < 5) begin
            tick();
            waited++;
        end
        chk("rstbus mem_req_before", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstbus mem_req",   32'(mem_req),   32'd0);
        chk("rstbus out_valid", 32'(out_valid), 32'd0);
        chk("rstbus in_ready",  32'(in_ready),  32'd1);
        tick();
        chk("rstbus no_result", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_access
`default_nettype wire
